// File: rtl/skel_pkg.sv
// Shared types and helpers for the thinning engine: FSM states, 3x3 neighbour
// slot numbering and the foreground test. Optional macro: SKEL_TWO_PASS_EN.
package skel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FETCH,
        ST_EVAL,
        ST_DONE
    } state_t;

    // Window slots, in raster order of the 3x3 neighbourhood
    localparam int NB_NW    = 0;
    localparam int NB_N     = 1;
    localparam int NB_NE    = 2;
    localparam int NB_W     = 3;
    localparam int NB_C     = 4;
    localparam int NB_E     = 5;
    localparam int NB_SW    = 6;
    localparam int NB_S     = 7;
    localparam int NB_SE    = 8;
    localparam int NB_COUNT = 9;

    function automatic logic is_fg(input logic [31:0] value);
        return value != 32'd0;
    endfunction

    function automatic int nb_drow(input int idx);
        return idx / 3 - 1;
    endfunction

    function automatic int nb_dcol(input int idx);
        return idx % 3 - 1;
    endfunction

endpackage

// File: rtl/skel_center_mask.sv
// Zhang-Suen centre-deletion decision from the 9 binarised window bits.
// pass_sel=0 applies sub-iteration 1, pass_sel=1 sub-iteration 2 (SKEL_TWO_PASS_EN).
module skel_center_mask
    import skel_pkg::*;
(
    input  logic [NB_COUNT-1:0] nb,
    input  logic                pass_sel,
    output logic                del
);

    logic [7:0] ring;
    logic [7:0] trans;
    logic [3:0] b_cnt;
    logic [3:0] a_cnt;
    logic       n, e, s, w;
    logic       cond_ok;

    // Clockwise ring starting at N; ring[7] wraps back to ring[0]
    assign ring = {nb[NB_NW], nb[NB_W], nb[NB_SW], nb[NB_S],
                   nb[NB_SE], nb[NB_E], nb[NB_NE], nb[NB_N]};

    for (genvar gi = 0; gi < 8; gi++) begin : g_trans
        assign trans[gi] = ~ring[gi] & ring[(gi + 1) % 8];
    end

    assign n = nb[NB_N];
    assign e = nb[NB_E];
    assign s = nb[NB_S];
    assign w = nb[NB_W];

    always_comb begin
        b_cnt = '0;
        a_cnt = '0;
        for (int i = 0; i < 8; i++) begin
            b_cnt = b_cnt + 4'(ring[i]);
            a_cnt = a_cnt + 4'(trans[i]);
        end
    end

    always_comb begin
        if (pass_sel) begin
            cond_ok = !(n & e & w) && !(n & s & w);
        end else begin
            cond_ok = !(n & e & s) && !(e & s & w);
        end
    end

    assign del = nb[NB_C] && (b_cnt >= 4'd2) && (b_cnt <= 4'd6) &&
                 (a_cnt == 4'd1) && cond_ok;

endmodule

// File: rtl/main_controller.sv
// Binary-image thinning controller: serial load, one 10-cycle window scan per pixel,
// streamed result. Optional macro: SKEL_TWO_PASS_EN (adds the second Zhang-Suen pass).
module main_controller
    import skel_pkg::*;
#(
    parameter int N          = 8,
    parameter int pixelWidth = 8,
    parameter int bitSize    = $clog2(N * N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [pixelWidth-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic                  out_valid,
    output logic [bitSize-1:0]    out_addr,
    output logic [pixelWidth-1:0] out_pixel
);

    localparam int                 NPIX     = N * N;
    localparam int                 RC_W     = (N > 1) ? $clog2(N) : 1;
    localparam logic [bitSize-1:0] LAST_PIX = bitSize'(NPIX - 1);

    state_t state_reg, state_next;

    logic [bitSize-1:0]    wr_addr_reg;
    logic                  phase_reg;
    logic [bitSize-1:0]    p_reg;
    logic [RC_W-1:0]       row_reg, col_reg;
    logic [3:0]            k_reg;
    logic                  rd_pend_reg, rd_in_reg;
    logic [3:0]            rd_idx_reg;
    logic [NB_COUNT-1:0]   window_reg, window_eff;
    logic [pixelWidth-1:0] centre_reg;
    logic [pixelWidth-1:0] img_rd_reg;
    logic [pixelWidth-1:0] src_pixel;
    logic                  pass_sel;

    logic                  load_cycle, wr_en, start, abort, fetching, evaluating;
    logic                  cap_fg, del;
    logic [pixelWidth-1:0] result_pixel;
    int                    nb_row, nb_col;
    logic                  nb_in;
    logic [bitSize-1:0]    nb_addr;

    logic [pixelWidth-1:0] img_ram [NPIX];

    assign load_cycle = we && (state_reg == ST_IDLE || state_reg == ST_LOAD || state_reg == ST_DONE);
    assign wr_en      = load_cycle && !phase_reg;
    assign start      = (state_reg == ST_LOAD) && !we;
    assign abort      = (state_reg == ST_FETCH || state_reg == ST_EVAL) && we;
    assign fetching   = (state_reg == ST_FETCH) && !we;
    assign evaluating = (state_reg == ST_EVAL) && !we;

    // Neighbour address for fetch slot k; off-image slots are flagged, not read
    always_comb begin
        nb_row  = int'(row_reg) + nb_drow(int'(k_reg));
        nb_col  = int'(col_reg) + nb_dcol(int'(k_reg));
        nb_in   = (nb_row >= 0) && (nb_row < N) && (nb_col >= 0) && (nb_col < N);
        nb_addr = '0;
        if (nb_in) begin
            nb_addr = bitSize'(nb_row * N + nb_col);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            img_ram[wr_addr_reg] <= data_in;
        end
        img_rd_reg <= img_ram[nb_addr];
    end

`ifdef SKEL_TWO_PASS_EN
    logic                  pass_reg;
    logic [pixelWidth-1:0] res_rd_reg;
    logic [pixelWidth-1:0] res_ram [NPIX];

    // Pass 1 results land here so pass 2 never sees a partly thinned source
    always_ff @(posedge clk) begin
        if (evaluating && !pass_reg) begin
            res_ram[p_reg] <= result_pixel;
        end
        res_rd_reg <= res_ram[nb_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_reg <= 1'b0;
        end else if (start || abort) begin
            pass_reg <= 1'b0;
        end else if (evaluating && p_reg == LAST_PIX) begin
            pass_reg <= 1'b1;
        end
    end

    assign src_pixel = pass_reg ? res_rd_reg : img_rd_reg;
    assign pass_sel  = pass_reg;
`else
    assign src_pixel = img_rd_reg;
    assign pass_sel  = 1'b0;
`endif

    assign cap_fg = rd_in_reg & is_fg(32'(src_pixel));

    // The last neighbour (SE) arrives during EVAL, so merge it combinationally
    always_comb begin
        window_eff = window_reg;
        if (rd_pend_reg) begin
            window_eff[rd_idx_reg] = cap_fg;
        end
    end

    skel_center_mask u_mask (
        .nb       (window_eff),
        .pass_sel (pass_sel),
        .del      (del)
    );

    assign result_pixel = del ? '0 : centre_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: if (we) state_next = ST_LOAD;
            ST_LOAD:          if (!we) state_next = ST_FETCH;
            ST_FETCH: begin
                if (we) state_next = ST_LOAD;
                else if (k_reg == 4'(NB_SE)) state_next = ST_EVAL;
            end
            ST_EVAL: begin
                if (we) state_next = ST_LOAD;
                else if (p_reg != LAST_PIX) state_next = ST_FETCH;
`ifdef SKEL_TWO_PASS_EN
                else state_next = pass_reg ? ST_DONE : ST_FETCH;
`else
                else state_next = ST_DONE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_reg <= '0;
            phase_reg   <= 1'b0;
            p_reg       <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            k_reg       <= '0;
            rd_pend_reg <= 1'b0;
            rd_in_reg   <= 1'b0;
            rd_idx_reg  <= '0;
            window_reg  <= '0;
            centre_reg  <= '0;
        end else begin
            rd_pend_reg <= fetching;
            rd_in_reg   <= nb_in;
            rd_idx_reg  <= k_reg;
            if (rd_pend_reg) begin
                window_reg[rd_idx_reg] <= cap_fg;
                if (rd_idx_reg == 4'(NB_C)) begin
                    centre_reg <= src_pixel;
                end
            end

            if (load_cycle) begin
                phase_reg <= ~phase_reg;
            end
            if (wr_en) begin
                wr_addr_reg <= (wr_addr_reg == LAST_PIX) ? '0 : wr_addr_reg + 1'b1;
            end

            if (start || abort) begin
                wr_addr_reg <= '0;
                phase_reg   <= 1'b0;
                p_reg       <= '0;
                row_reg     <= '0;
                col_reg     <= '0;
                k_reg       <= '0;
            end else if (fetching) begin
                k_reg <= (k_reg == 4'(NB_SE)) ? 4'd0 : k_reg + 4'd1;
            end else if (evaluating) begin
                k_reg <= '0;
                if (p_reg == LAST_PIX) begin
                    p_reg   <= '0;
                    row_reg <= '0;
                    col_reg <= '0;
                end else begin
                    p_reg <= p_reg + 1'b1;
                    if (col_reg == RC_W'(N - 1)) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_addr  = '0;
        out_pixel = '0;
        case (state_reg)
            ST_FETCH: busy = 1'b1;
            ST_EVAL: begin
                busy = 1'b1;
`ifdef SKEL_TWO_PASS_EN
                out_valid = !we && pass_reg;
`else
                out_valid = !we;
`endif
                if (out_valid) begin
                    out_addr  = p_reg;
                    out_pixel = result_pixel;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_main_controller.sv
// Directed bench for main_controller: golden Zhang-Suen model feeds a scoreboard
// that is drained on every out_valid strobe. Built without SKEL_TWO_PASS_EN.
module tb_main_controller;

    localparam int N    = 8;
    localparam int PW   = 8;
    localparam int AW   = 6;
    localparam int NPIX = N * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we = 1'b0;
    logic [PW-1:0] data_in = '0;
    logic          busy, done, out_valid;
    logic [AW-1:0] out_addr;
    logic [PW-1:0] out_pixel;

    main_controller #(.N(N), .pixelWidth(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .data_in   (data_in),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_pixel (out_pixel)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int pix;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    int   img [NPIX];
    int   gold [NPIX];
    exp_t sb [$];
    int   cyc = 0;
    int   strobes = 0;
    int   last_cyc = 0;
    int   busy_cycles = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int px(input int r, input int c);
        if (r < 0 || r >= N || c < 0 || c >= N) return 0;
        return (img[r * N + c] != 0) ? 1 : 0;
    endfunction

    // Reference Zhang-Suen sub-iteration 1 over the whole source image
    task automatic build_gold();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int n, ne, e, se, s, sw, w, nw, b, a;
                int seq [9];
                bit del;
                n  = px(r - 1, c);     ne = px(r - 1, c + 1);
                e  = px(r, c + 1);     se = px(r + 1, c + 1);
                s  = px(r + 1, c);     sw = px(r + 1, c - 1);
                w  = px(r, c - 1);     nw = px(r - 1, c - 1);
                seq = '{n, ne, e, se, s, sw, w, nw, n};
                b = n + ne + e + se + s + sw + w + nw;
                a = 0;
                for (int k = 0; k < 8; k++) if (seq[k] == 0 && seq[k + 1] == 1) a++;
                del = (px(r, c) == 1) && b >= 2 && b <= 6 && a == 1 &&
                      (n * e * s == 0) && (e * s * w == 0);
                gold[r * N + c] = del ? 0 : img[r * N + c];
            end
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = 0;
    endtask

    task automatic push_expected(input int count);
        build_gold();
        for (int i = 0; i < count; i++) begin
            exp_t x;
            x.addr = i;
            x.pix  = gold[i];
            sb.push_back(x);
        end
    endtask

    // Each pixel is held for two clocks; pixels past NPIX carry extra_val
    task automatic load_pixels(input int count, input int extra_val);
        for (int i = 0; i < count; i++) begin
            we      = 1'b1;
            data_in = PW'((i < NPIX) ? img[i] : extra_val);
            @(posedge clk); #1;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_image(input string tag);
        push_expected(NPIX);
        busy_cycles = 0;
        strobes     = 0;
        we          = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_cycles"}, busy_cycles, 640);
        check({tag, "_strobes"}, strobes, NPIX);
        check({tag, "_sb_left"}, sb.size(), 0);
        $display("run %s: strobes=%0d busy_cycles=%0d done=%0b", tag, strobes, busy_cycles, done);
        sb.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_addr"}, out_addr, 0);
        check({tag, "_out_pixel"}, out_pixel, 0);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (out_valid) begin
            if (strobes > 0) check("strobe_gap", cyc - last_cyc, 10);
            last_cyc = cyc;
            strobes++;
            if (sb.size() == 0) begin
                check("unexpected_strobe_addr", out_addr, -1);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("out_addr", out_addr, x.addr);
                check("out_pixel", out_pixel, x.pix);
                $display("pixel addr=%0d value=%0d expected=%0d", out_addr, out_pixel, x.pix);
            end
        end
    end

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("idle_we0_busy", busy, 0);

        // Reset in the middle of a load
        clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = i + 1;
        load_pixels(10, 0);
        we = 1'b0;
        rst_n = 1'b0;
        #1 check_idle_outputs("midload_reset");
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("midload_reset_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        clear_img();
        img[27] = 200;
        load_pixels(NPIX, 0);
        run_image("after_reset");

        // All-zero image; done stays high
        clear_img();
        load_pixels(NPIX, 0);
        check("load_clears_done", done, 0);
        check("load_busy", busy, 0);
        run_image("all_zero");
        repeat (5) @(posedge clk);
        #1 check("done_sticky", done, 1);
        check("done_busy_low", busy, 0);

        // Isolated pixel
        clear_img();
        img[27] = 200;
        load_pixels(NPIX, 0);
        run_image("isolated");

        // Solid 3x3 block
        clear_img();
        for (int r = 2; r <= 4; r++) for (int c = 2; c <= 4; c++) img[r * N + c] = 255;
        load_pixels(NPIX, 0);
        run_image("block3x3");

        // Horizontal line
        clear_img();
        for (int c = 1; c <= 6; c++) img[3 * N + c] = 1;
        load_pixels(NPIX, 0);
        run_image("hline");

        // Write address wraps: the 65th pixel overwrites address 0
        clear_img();
        load_pixels(NPIX + 1, 99);
        img[0] = 99;
        run_image("wrap");

        // Abort at pixel index 20 of a pass
        clear_img();
        for (int r = 2; r <= 4; r++) for (int c = 2; c <= 4; c++) img[r * N + c] = 255;
        load_pixels(NPIX, 0);
        push_expected(20);
        strobes = 0;
        we = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (strobes >= 20) break;
        end
        check("abort_strobes_before", strobes, 20);
        clear_img();
        img[27] = 77;
        img[0]  = 5;
        we      = 1'b1;
        data_in = PW'(img[0]);
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_sb_left", sb.size(), 0);
        load_pixels(NPIX, 0);
        run_image("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
